// File: rtl/fp_int_to_float_seq_if.sv
// Operand/result handshake bundle for the sequential int-to-binary32 converter.
interface fp_int_to_float_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/fp_int_to_float_seq.sv
// Sequential 32-bit int to IEEE-754 binary32 converter, round-to-nearest-even.
// Normalises one bit per cycle, then rounds in a single step.
module fp_int_to_float_seq (
  input  logic                  CLK,
  input  logic                  RESET,
  fp_int_to_float_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_inexact_q, out_inexact_d;

  logic        in_ready_s;
  logic        accept_s;
  logic        sign_in_s;
  logic [31:0] acc_mag_s;
  logic [22:0] rnd_m_s;
  logic        rnd_g_s;
  logic        rnd_st_s;
  logic        rnd_up_s;
  logic [23:0] rnd_sum_s;

  // Nearest-even: bump only above the halfway point, or exactly at it with an odd lsb.
  function automatic logic round_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  assign in_ready_s      = (state_q == IDLE);
  assign accept_s        = bus.in_valid & in_ready_s;
  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_data    = out_data_q;
  assign bus.out_inexact = out_inexact_q;

  // Operand magnitude and rounding datapath
  always_comb begin
    sign_in_s = bus.in_signed & bus.in_data[31];
    acc_mag_s = sign_in_s ? (~bus.in_data + 32'd1) : bus.in_data;
    rnd_m_s   = mag_q[30:8];
    rnd_g_s   = mag_q[7];
    rnd_st_s  = |mag_q[6:0];
    rnd_up_s  = round_up(rnd_m_s[0], rnd_g_s, rnd_st_s);
    rnd_sum_s = {1'b0, rnd_m_s} + {23'd0, rnd_up_s};
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    mag_d         = mag_q;
    exp_d         = exp_q;
    sign_d        = sign_q;
    out_data_d    = out_data_q;
    out_inexact_d = out_inexact_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sign_d = sign_in_s;
          mag_d  = acc_mag_s;
          exp_d  = 8'd158;
          if (acc_mag_s == 32'd0) begin
            // Zero is always +0, even for a signed operand.
            out_data_d    = 32'd0;
            out_inexact_d = 1'b0;
            state_d       = DONE;
          end else begin
            state_d = NORM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      ROUND: begin
        // A carry out of the mantissa leaves it zero and bumps the exponent.
        exp_d         = exp_q + {7'd0, rnd_sum_s[23]};
        out_data_d    = {sign_q, exp_q + {7'd0, rnd_sum_s[23]}, rnd_sum_s[22:0]};
        out_inexact_d = rnd_g_s | rnd_st_s;
        state_d       = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      mag_q         <= 32'd0;
      exp_q         <= 8'd0;
      sign_q        <= 1'b0;
      out_data_q    <= 32'd0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      exp_q         <= exp_d;
      sign_q        <= sign_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

endmodule

// File: tb/tb_fp_int_to_float_seq.sv
// Directed, table-driven bench for fp_int_to_float_seq plus handshake/reset sequences.
module tb_fp_int_to_float_seq;

  logic CLK;
  logic RESET;
  fp_int_to_float_seq_if bus ();

  fp_int_to_float_seq dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic        sgn;
    logic [31:0] res;
    logic        inex;
    int          lat;
  } vec_t;

  vec_t vecs [12];
  int   tests;
  int   fails;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Drive one operand, wait for the result, complete the output handshake.
  task automatic convert(input logic [31:0] data, input logic sgn,
                         output logic [31:0] res, output logic inex, output int lat);
    int n;
    @(negedge CLK);
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_signed = sgn;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    res = bus.out_data;
    inex = bus.out_inexact;
    lat = n;
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic        inex;
    int          lat;
    int          n;
    logic        seen;

    tests = 0;
    fails = 0;

    vecs[0]  = '{32'h00000001, 1'b1, 32'h3F800000, 1'b0, 34};
    vecs[1]  = '{32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 34};
    vecs[2]  = '{32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1, 3};
    vecs[3]  = '{32'h80000000, 1'b1, 32'hCF000000, 1'b0, 3};
    vecs[4]  = '{32'h80000000, 1'b0, 32'h4F000000, 1'b0, 3};
    vecs[5]  = '{32'h01000001, 1'b0, 32'h4B800000, 1'b1, 10};
    vecs[6]  = '{32'h01000003, 1'b0, 32'h4B800002, 1'b1, 10};
    vecs[7]  = '{32'h00FFFFFF, 1'b0, 32'h4B7FFFFF, 1'b0, 11};
    vecs[8]  = '{32'h00000000, 1'b1, 32'h00000000, 1'b0, 1};
    vecs[9]  = '{32'h00000003, 1'b0, 32'h40400000, 1'b0, 33};
    vecs[10] = '{32'hFEFFFFFD, 1'b1, 32'hCB800002, 1'b1, 10};
    vecs[11] = '{32'h7FFFFFFF, 1'b1, 32'h4F000000, 1'b1, 4};

    RESET         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready",    {31'd0, bus.in_ready},    32'd1);
    chk("rst_out_valid",   {31'd0, bus.out_valid},   32'd0);
    chk("rst_out_data",    bus.out_data,             32'd0);
    chk("rst_out_inexact", {31'd0, bus.out_inexact}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].data, vecs[i].sgn, res, inex, lat);
      chk($sformatf("vec%0d_data", i),    res,              vecs[i].res);
      chk($sformatf("vec%0d_inexact", i), {31'd0, inex},    {31'd0, vecs[i].inex});
      chk($sformatf("vec%0d_latency", i), lat,              vecs[i].lat);
    end

    // Zero result under backpressure while a second operand waits upstream.
    @(negedge CLK);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00000000;
    bus.in_signed = 1'b1;
    @(posedge CLK);
    #1;
    bus.in_data = 32'h00000002;
    chk("bp_valid_t1", {31'd0, bus.out_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("bp_hold_data%0d", c),  bus.out_data,             32'd0);
      chk($sformatf("bp_hold_ready%0d", c), {31'd0, bus.in_ready},    32'd0);
      chk($sformatf("bp_hold_valid%0d", c), {31'd0, bus.out_valid},   32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_second_accepted", {31'd0, bus.in_ready}, 32'd0);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("bp_second_data",    bus.out_data, 32'h40000000);
    chk("bp_second_latency", n,            33);
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of normalisation discards the operand.
    @(negedge CLK);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00000001;
    bus.in_signed = 1'b0;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk("mid_rst_in_ready",    {31'd0, bus.in_ready},    32'd1);
    chk("mid_rst_out_valid",   {31'd0, bus.out_valid},   32'd0);
    chk("mid_rst_out_data",    bus.out_data,             32'd0);
    chk("mid_rst_out_inexact", {31'd0, bus.out_inexact}, 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("post_rst_no_valid", {31'd0, seen},         32'd0);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    convert(32'h00000003, 1'b0, res, inex, lat);
    chk("post_rst_data",    res,           32'h40400000);
    chk("post_rst_inexact", {31'd0, inex}, 32'd0);
    chk("post_rst_latency", lat,           33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_int_to_float_seq.md
# fp_int_to_float_seq

Sequential integer-to-single-precision converter for the CPU FPU. It takes a 32-bit signed or unsigned integer and produces an IEEE-754 binary32 result, rounded to nearest-even. It is the int-to-float counterpart of the FPU's float-to-integer converter and sits on the same operand/result path. Normalisation is iterative, one bit per cycle. The block has valid/ready handshakes on both sides.

## Interface
- No parameters; all widths are fixed at 32 bits.
- CLK  input  1  sole clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- in_data  input  32  integer operand.
- in_signed  input  1  1: treat in_data as two's complement; 0: unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- out_data  output  32  binary32 result {sign, exp[7:0], mant[22:0]}.
- out_inexact  output  1  result was rounded (guard or sticky nonzero).

## Operation
- States:
  - IDLE → NORM on accept, when the magnitude is nonzero.
  - IDLE → DONE on accept, when the magnitude is zero.
  - NORM → ROUND when mag[31]=1.
  - ROUND → DONE.
  - DONE → IDLE on out_valid & out_ready.
- Accept = in_valid & in_ready. On accept, register:
  - sign = in_signed & in_data[31]
  - mag = sign ? (~in_data + 1) : in_data, a 32-bit unsigned value; 0x80000000 signed gives mag 0x80000000
  - exp = 8'd158 (127+31)
- NORM: if mag[31]=0, then mag ← mag<<1 and exp ← exp−1; otherwise go to ROUND. A magnitude with k leading zeros spends k+1 cycles in NORM.
- ROUND:
  - m = mag[30:8], G = mag[7], S = |mag[6:0].
  - Round up when G & (S | m[0]).
  - If m = 0x7FFFFF and the block rounds up, then m ← 0 and exp ← exp+1. This occurs only for mag ≥ 0xFFFFFF80 and gives 0x4F800000 for unsigned inputs.
  - Register out_data = {sign, exp, m}, out_inexact = G|S.
- Zero input: out_data = 0x00000000 (+0, even when signed), out_inexact = 0.
- No NaN, infinity or denormal outputs are possible; exp always lies in 127..159.
- DONE:
  - out_valid = 1.
  - out_data and out_inexact are held stable until out_ready.
  - No new operand is accepted.

## Timing
- Reset values (asynchronous, immediate): state IDLE, in_ready 1, out_valid 0, out_data 0, out_inexact 0; mag, exp and sign are 0.
- With accept at cycle T, out_valid rises at:
  - T+1 for a zero magnitude;
  - T+3+k for a nonzero magnitude with k leading zeros (k = 0..31).
- The best case is T+3 (bit 31 set). The worst case is T+34 (magnitude 1).
- in_ready is registered/state-decoded and goes low the cycle after accept. It returns high the cycle after the output handshake, so back-to-back throughput is one result per latency+1 cycles.
- in_valid while busy: ignored. The upstream stage holds it; no buffering.
- out_ready asserted before out_valid: no effect.
- A RESET assertion in any state aborts the conversion. The in-flight operand is discarded and no out_valid pulse occurs. Operation restarts in IDLE on the first edge after deassertion.
- in_data and in_signed are sampled only on the accept edge. Changes afterwards do not affect the result.

## Test plan
- Value 1: signed in_data=0x00000001 accepted at T → out_data 0x3F800000, out_inexact 0, out_valid first at T+34.
- Minus one and max unsigned: signed 0xFFFFFFFF → 0xBF800000, exact. Unsigned 0xFFFFFFFF → 0x4F800000, out_inexact 1 (rounding mantissa overflow).
- Most negative: signed 0x80000000 → 0xCF000000, exact, out_valid at T+3. Unsigned 0x80000000 → 0x4F000000.
- Ties to even, unsigned inputs:
  - 0x01000001 → 0x4B800000, inexact 1 (tie rounded down).
  - 0x01000003 → 0x4B800002, inexact 1 (tie rounded up).
  - 0x00FFFFFF → 0x4B7FFFFF, exact.
- Zero and backpressure: signed 0x00000000 → 0x00000000 at T+1.
  - Hold out_ready low for 5 cycles while in_valid stays high with 0x00000002.
  - Over those 5 cycles: out_data stable and in_ready 0.
  - The second operand is accepted the cycle after the handshake and yields 0x40000000.
- Reset mid-NORM: accept 0x00000001, pull RESET low 10 cycles later.
  - During and after reset: outputs return to their reset values at once; no out_valid.
  - After release: in_ready is 1; a fresh 0x00000003 gives 0x40400000.
